// File: rtl/multdiv_iterative.sv
// Iterative signed 32-bit multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on magnitudes, sign fix-up in a final cycle.
module multdiv_iterative #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  // Handshake: a one-cycle ctrl_MULT/ctrl_DIV pulse starts an op in any state
  // (restarting one in flight); busy stays high until the one-cycle
  // data_resultRDY pulse, with data_result/data_exception valid alongside it.

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      counter;
  logic               op_mul;
  logic               sign;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   rem;

  logic               start;
  logic [WIDTH-1:0]   opa_mag;
  logic [WIDTH-1:0]   opb_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] mul_signed;
  logic [WIDTH-1:0]   div_signed;
  logic [WIDTH-1:0]   fix_result;
  logic               fix_exc;
  logic               last_iter;

  assign start     = ctrl_MULT | ctrl_DIV;
  assign opa_mag   = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
  assign opb_mag   = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;
  assign last_iter = (counter == CW'(WIDTH - 1));

  // Multiply step: add |A| into the upper half when the current multiplier bit
  // is set, then shift the whole accumulator right by one.
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_mag} : '0);

  // Divide step: bring the next dividend bit into the remainder and try a
  // 33-bit subtraction; its borrow decides the quotient bit.
  assign div_shift = {rem, acc[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, b_mag};
  assign div_ge    = ~div_diff[WIDTH];

  assign mul_signed = sign ? (~acc + 1'b1) : acc;
  assign div_signed = sign ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];

  always_comb begin
    fix_result = '0;
    fix_exc    = 1'b0;
    if (op_mul) begin
      fix_result = mul_signed[WIDTH-1:0];
      fix_exc    = ~((&mul_signed[2*WIDTH-1:WIDTH-1]) | ~(|mul_signed[2*WIDTH-1:WIDTH-1]));
    end else if (b_mag == '0) begin
      fix_result = '0;
      fix_exc    = 1'b1;
    end else begin
      // A positive quotient of 2^31 only arises from 0x80000000 / -1.
      fix_result = div_signed;
      fix_exc    = acc[WIDTH-1] & ~sign;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      counter        <= '0;
      op_mul         <= 1'b0;
      sign           <= 1'b0;
      a_mag          <= '0;
      b_mag          <= '0;
      acc            <= '0;
      rem            <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else if (start) begin
      state          <= ctrl_MULT ? MUL : DIV;
      op_mul         <= ctrl_MULT;
      counter        <= '0;
      sign           <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      a_mag          <= opa_mag;
      b_mag          <= opb_mag;
      acc            <= ctrl_MULT ? {{WIDTH{1'b0}}, opb_mag} : {{WIDTH{1'b0}}, opa_mag};
      rem            <= '0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b1;
    end else begin
      data_resultRDY <= 1'b0;
      case (state)
        IDLE: begin
          counter <= '0;
        end
        MUL: begin
          acc <= {mul_sum, acc[WIDTH-1:1]};
          if (last_iter) begin
            counter <= '0;
            state   <= FIX;
          end else begin
            counter <= counter + CW'(1);
          end
        end
        DIV: begin
          rem               <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
          acc[WIDTH-1:0]    <= {acc[WIDTH-2:0], div_ge};
          if (last_iter) begin
            counter <= '0;
            state   <= FIX;
          end else begin
            counter <= counter + CW'(1);
          end
        end
        FIX: begin
          data_result    <= fix_result;
          data_exception <= fix_exc;
          data_resultRDY <= 1'b1;
          busy           <= 1'b0;
          counter        <= '0;
          state          <= DONE;
        end
        DONE: begin
          counter <= '0;
          state   <= IDLE;
        end
        default: begin
          counter <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_iterative.sv
// Bench for multdiv_iterative: directed operations checked against an
// arithmetic reference model, with a per-cycle compare of busy/RDY/result.
module tb_multdiv_iterative;

  logic        clock;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  multdiv_iterative #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc = cyc + 1;

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          chk_en   = 0;
  bit          pending  = 0;
  int          start_edge;
  int          due;
  logic [31:0] exp_q[$];
  logic [31:0] held_res = '0;
  logic        held_exc = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference arithmetic straight from the signed definitions.
  function automatic void model_op(input bit m, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic e);
    longint p;
    int     q;
    logic [31:0] lo;
    if (m) begin
      p  = longint'($signed(a)) * longint'($signed(b));
      lo = p[31:0];
      r  = lo;
      e  = (p != longint'($signed(lo)));
    end else if (b == 32'd0) begin
      r = 32'd0;
      e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000;
      e = 1'b1;
    end else begin
      q = $signed(a) / $signed(b);
      r = q;
      e = 1'b0;
    end
  endfunction

  // Compare process: the start edge is posedge number start_edge; busy is
  // expected for the 33 sampled cycles after it, RDY on the one after that.
  always @(negedge clock) begin
    if (chk_en) begin
      bit exp_rdy;
      bit exp_busy;
      exp_rdy  = pending && (cyc == due);
      exp_busy = pending && (cyc >= start_edge) && (cyc < due);
      if (exp_rdy) begin
        held_res = exp_q.pop_front();
        held_exc = exp_q.pop_front();
        pending  = 0;
      end
      chk("rdy", {31'd0, data_resultRDY}, {31'd0, exp_rdy});
      chk("busy", {31'd0, busy}, {31'd0, exp_busy});
      chk("result", data_result, held_res);
      chk("exception", {31'd0, data_exception}, {31'd0, held_exc});
    end
  end

  // ---------------- driver tasks ----------------
  // Caller is just after a falling edge; the pulse is sampled on the next rise.
  task automatic launch(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        e;
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    data_operandA = a;
    data_operandB = b;
    model_op(m, a, b, r, e);
    exp_q.delete();
    exp_q.push_back(r);
    exp_q.push_back({31'd0, e});
    start_edge = cyc + 1;
    due        = start_edge + 33;
    pending    = 1;
    @(negedge clock); #1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom();
    data_operandB = $urandom();
  endtask

  task automatic start_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock); #1;
    launch(m, d, a, b);
  endtask

  task automatic wait_done();
    int guard = 0;
    while (pending && guard < 100) begin
      @(negedge clock); #1;
      guard++;
    end
    n_checks++;
    if (pending) begin
      n_fail++;
      $display("FAIL timeout at cycle %0d: got no completion expected completion", cyc);
      pending = 0;
    end
  endtask

  task automatic run(input string name, input bit m, input bit d, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp_r, input logic exp_e);
    start_op(m, d, a, b);
    wait_done();
    chk({name, "_result"}, data_result, exp_r);
    chk({name, "_exc"}, {31'd0, data_exception}, {31'd0, exp_e});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = '0; data_operandB = '0;
    #1 reset = 1'b1;
    #1 chk_en = 1;
    chk("reset_result", data_result, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clock);
    #1 reset = 1'b0;

    run("mul_7_m6",      1, 0, 32'd7,          32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0);
    run("mul_ovf",       1, 0, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b1);
    run("mul_min_1",     1, 0, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0);
    run("mul_min_m1",    1, 0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    run("mul_m1_m1",     1, 0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1,         1'b0);
    run("mul_zero",      1, 0, 32'd0,          32'hFFFF_FFFF, 32'd0,         1'b0);
    run("div_m100_7",    0, 1, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFF2, 1'b0);
    run("div_by_zero",   0, 1, 32'd5,          32'd0,         32'd0,         1'b1);
    run("div_min_m1",    0, 1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    run("div_7_m2",      0, 1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0);
    run("div_min_1",     0, 1, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0);
    run("both_ctrl",     1, 1, 32'd6,          32'd3,         32'd18,        1'b0);

    // Restart a multiply with a divide ten edges later.
    start_op(1, 0, 32'd12345, 32'd678);
    repeat (8) @(negedge clock);
    start_op(0, 1, 32'd100, 32'd10);
    wait_done();
    chk("abort_result", data_result, 32'd10);

    // Back-to-back: new start sampled on the edge leaving DONE.
    start_op(1, 0, 32'd9, 32'd9);
    wait_done();
    chk("done_rdy", {31'd0, data_resultRDY}, 32'd1);
    launch(0, 1, 32'd81, 32'hFFFF_FFF7);
    wait_done();
    chk("b2b_result", data_result, 32'hFFFF_FFF7);

    // Reset in the middle of a multiply.
    start_op(1, 0, 32'd3, 32'd5);
    repeat (4) @(negedge clock);
    @(negedge clock); #1;
    reset    = 1'b1;
    pending  = 0;
    exp_q.delete();
    held_res = '0;
    held_exc = 1'b0;
    #1;
    chk("rst_result", data_result, 32'd0);
    chk("rst_exc", {31'd0, data_exception}, 32'd0);
    chk("rst_rdy", {31'd0, data_resultRDY}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clock);
    #1 reset = 1'b0;
    repeat (40) @(negedge clock);

    run("post_reset",    1, 0, 32'h0001_2345,  32'h0000_0100, 32'h0123_4500, 1'b0);

    repeat (3) @(negedge clock);
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multdiv_iterative.md
Name: multdiv_iterative

Overview:
- Multi-cycle signed 32-bit multiply/divide unit in the execute stage, alongside the single-cycle ALU.
- Consumes the same register operands as the ALU.
- Uses one shift-by-1 datapath per iteration, the same primitive the ALU's logical-shift network is built from.
- The pipeline stalls on busy and resumes on data_resultRDY.

Parameters:
- WIDTH, 32, operand/result width. Only 32 is supported; the iteration counter runs WIDTH cycles.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- data_operandA  input  32  multiplicand / dividend, two's complement
- data_operandB  input  32  multiplier / divisor, two's complement
- ctrl_MULT  input  1  single-cycle start pulse for a multiply
- ctrl_DIV  input  1  single-cycle start pulse for a divide
- data_result  output  32  product low word or quotient
- data_exception  output  1  overflow / divide-by-zero flag, valid with data_resultRDY
- data_resultRDY  output  1  one-cycle completion pulse
- busy  output  1  high while an operation is in flight

Behaviour:
- Reset (async, any state):
  - state=IDLE, counter=0.
  - data_result=0, data_exception=0, data_resultRDY=0, busy=0.
  - Any in-flight operation is discarded; no RDY is produced for it.
- States: IDLE, MUL, DIV, FIX, DONE.
- Start:
  - On the edge where ctrl_MULT or ctrl_DIV is high, operands are latched and state -> MUL or DIV.
  - counter=0, busy=1.
  - Operands need not be held after the start edge.
- Simultaneous ctrl_MULT and ctrl_DIV: the multiply wins.
- Start while busy: the current operation is aborted and restarts with the new operands and opcode. No RDY is issued for the aborted one.
- Pre-processing at start:
  - Magnitudes |A| and |B| are captured as 32-bit unsigned. 0x80000000 maps to 2^31.
  - sign = A[31]^B[31] is stored.
- MUL:
  - Radix-2 shift-add over a 64-bit accumulator, one bit of |B| per cycle, LSB first.
  - 32 iterations, counter 0..31, then -> FIX.
- DIV:
  - Restoring division, one quotient bit per cycle, MSB first.
  - 33-bit partial remainder; quotient built by left shift.
  - 32 iterations, then -> FIX.
- FIX (1 cycle):
  - Negate the magnitude result if sign=1.
  - Compute the exception flag.
  - Register data_result and data_exception, then -> DONE.
- DONE (1 cycle):
  - data_resultRDY=1, busy=0, then -> IDLE.
  - A start in DONE is accepted; RDY is still asserted that cycle.
- Latency: start edge in cycle N gives data_resultRDY high in exactly cycle N+34, for one cycle.
- data_result and data_exception hold their values until the next FIX; they are not cleared in IDLE.
- Multiply arithmetic:
  - data_result = low 32 bits of the signed 64-bit product.
  - data_exception=1 iff product bits [63:31] are not all equal, i.e. the product does not fit in signed 32.
  - Zero operand gives product 0, exception 0, and no sign applied.
- Divide arithmetic:
  - Quotient truncates toward zero; the remainder is discarded.
  - B=0: data_result=0, data_exception=1. Iterations still run, so latency is unchanged.
  - 0x80000000 / 0xFFFFFFFF: data_result=0x80000000, data_exception=1.
  - All other cases: data_exception=0.
- Counter: wraps only via the state transition, never free-running. It is held at 0 in IDLE and DONE.

Test Plan:
- Reset, then ctrl_MULT with A=7, B=0xFFFFFFFA (-6) at cycle N -> busy high N+1..N+33; RDY only at N+34; result 0xFFFFFFD6, exception 0.
- ctrl_MULT with A=0x00010000, B=0x00010000 -> result 0x00000000, exception 1. Also A=0x80000000, B=1 -> result 0x80000000, exception 0.
- ctrl_DIV with A=0xFFFFFF9C (-100), B=7 -> result 0xFFFFFFF2 (-14), exception 0. Also A=5, B=0 -> result 0, exception 1, RDY still at N+34.
- ctrl_DIV with A=0x80000000, B=0xFFFFFFFF -> result 0x80000000, exception 1. Also ctrl_MULT and ctrl_DIV together with A=6, B=3 -> result 18, i.e. multiply taken.
- ctrl_MULT at N, then ctrl_DIV with A=100, B=10 at N+10 -> no RDY at N+34; single RDY at N+44 with result 10.
- ctrl_MULT at N, reset asserted mid-cycle N+5 -> all outputs 0 immediately; no RDY within 40 cycles; the next op behaves normally.
